// File: rtl/mst_data_chk_if.sv
// Channel-0 receive stream: one 32-bit word per cycle when ch0_vld is high.
// The read path drives it (master); the loopback checker observes it (slave).
interface mst_data_chk_if;
   logic        ch0_vld;
   logic [31:0] ch0_dat;

   modport master (output ch0_vld, output ch0_dat);
   modport slave  (input  ch0_vld, input  ch0_dat);
endinterface

// File: rtl/mst_data_chk.sv
// Loopback checker for the incrementing channel-0 test pattern (16- or 32-bit mode).
// Seeds on the first word, then counts words and mismatches; all status is registered.
module mst_data_chk #(
   parameter int ERR_W  = 16,
   parameter int CNT_W  = 32,
   parameter bit RESYNC = 1'b1,
   parameter bit SEED0  = 1'b0
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               bus16,
   input  logic               clr,
   mst_data_chk_if.slave      ch,
   output logic               locked,
   output logic               chk_err,
   output logic [ERR_W-1:0]   err_cnt,
   output logic [CNT_W-1:0]   word_cnt,
   output logic [31:0]        bad_dat
);

   typedef enum logic {IDLE, LOCK} state_t;

   state_t             state_reg,    state_next;
   logic               mode16_reg,   mode16_next;
   logic [31:0]        exp_reg,      exp_next;
   logic               chk_err_reg,  chk_err_next;
   logic [ERR_W-1:0]   err_cnt_reg,  err_cnt_next;
   logic [CNT_W-1:0]   word_cnt_reg, word_cnt_next;
   logic [31:0]        bad_dat_reg,  bad_dat_next;
   logic               mism;

   // Natural binary wrap gives the FFFF_FFFF->0 and FFFF->0 boundaries for free.
   function automatic logic [31:0] next_val(input logic [31:0] x, input logic m16);
      logic [31:0] r;
      if (m16) r = {16'h0, x[15:0] + 16'd1};
      else     r = x + 32'd1;
      return r;
   endfunction

   function automatic logic mismatch(input logic [31:0] d, input logic [31:0] e,
                                     input logic m16);
      logic r;
      if (m16) r = (d[15:0] != e[15:0]) || (d[31:16] != 16'h0);
      else     r = (d != e);
      return r;
   endfunction

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg    <= IDLE;
         mode16_reg   <= 1'b0;
         exp_reg      <= 32'h0;
         chk_err_reg  <= 1'b0;
         err_cnt_reg  <= '0;
         word_cnt_reg <= '0;
         bad_dat_reg  <= 32'h0;
      end else begin
         state_reg    <= state_next;
         mode16_reg   <= mode16_next;
         exp_reg      <= exp_next;
         chk_err_reg  <= chk_err_next;
         err_cnt_reg  <= err_cnt_next;
         word_cnt_reg <= word_cnt_next;
         bad_dat_reg  <= bad_dat_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      mode16_next   = mode16_reg;
      exp_next      = exp_reg;
      chk_err_next  = chk_err_reg;
      err_cnt_next  = err_cnt_reg;
      word_cnt_next = word_cnt_reg;
      bad_dat_next  = bad_dat_reg;
      mism          = 1'b0;

      // clr outranks a coincident word: that word is dropped entirely.
      if (clr) begin
         state_next    = IDLE;
         mode16_next   = 1'b0;
         exp_next      = 32'h0;
         chk_err_next  = 1'b0;
         err_cnt_next  = '0;
         word_cnt_next = '0;
         bad_dat_next  = 32'h0;
      end else if (ch.ch0_vld) begin
         if (state_reg == IDLE) begin
            state_next    = LOCK;
            mode16_next   = bus16;
            word_cnt_next = CNT_W'(1);
            if (SEED0) begin
               mism     = mismatch(ch.ch0_dat, 32'h0, bus16);
               exp_next = RESYNC ? next_val(ch.ch0_dat, bus16) : next_val(32'h0, bus16);
            end else begin
               exp_next = next_val(ch.ch0_dat, bus16);
            end
         end else begin
            word_cnt_next = word_cnt_reg + CNT_W'(1);
            mism          = mismatch(ch.ch0_dat, exp_reg, mode16_reg);
            if (!mism || RESYNC) exp_next = next_val(ch.ch0_dat, mode16_reg);
            else                 exp_next = next_val(exp_reg, mode16_reg);
         end

         if (mism) begin
            chk_err_next = 1'b1;
            bad_dat_next = ch.ch0_dat;
            if (!(&err_cnt_reg)) err_cnt_next = err_cnt_reg + ERR_W'(1);
         end
      end
   end

   assign locked   = (state_reg == LOCK);
   assign chk_err  = chk_err_reg;
   assign err_cnt  = err_cnt_reg;
   assign word_cnt = word_cnt_reg;
   assign bad_dat  = bad_dat_reg;

endmodule
